ocm_arbiter: RTL and testbench

//  Shared on-chip-memory (OCM) arbiter/controller downstream of each core's MEM-stage atomic/OCM interface.

---
 rtl/ocm_arbiter_if.sv | 42 ++++
 rtl/ocm_arbiter.sv | 185 ++++++++++++++++++
 tb/tb_ocm_arbiter.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/ocm_arbiter_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module  : ocm_arbiter_if
// Brief   : Core-side request/response bundle plus the sync RAM port of the
//           shared OCM arbiter. The arbiter uses the slave view and the
//           cores/RAM side uses the master view.
// Revision: 1.0
// ---------------------------------------------------------------------------
interface ocm_arbiter_if #(
   parameter int NUM_CORES = 2,
   parameter int ADDR_BITS = 12,
   parameter int IDX_BITS  = 1
);
   logic [NUM_CORES-1:0]           i_request;
   logic [NUM_CORES-1:0]           i_is_atomic;
   logic [NUM_CORES*ADDR_BITS-1:0] i_addr;
   logic [NUM_CORES*4-1:0]         i_dm_write;
   logic [NUM_CORES*32-1:0]        i_wdata;
   logic [NUM_CORES-1:0]           o_grant;
   logic [IDX_BITS-1:0]            o_grant_id;
   logic [NUM_CORES-1:0]           o_data_valid;
   logic [NUM_CORES-1:0]           o_data_write_valid;
   logic [31:0]                    o_rdata;
   logic                           o_mem_en;
   logic [3:0]                     o_mem_we;
   logic [ADDR_BITS-1:0]           o_mem_addr;
   logic [31:0]                    o_mem_wdata;
   logic [31:0]                    i_mem_rdata;

   modport slave (
      input  i_request, i_is_atomic, i_addr, i_dm_write, i_wdata, i_mem_rdata,
      output o_grant, o_grant_id, o_data_valid, o_data_write_valid, o_rdata,
      output o_mem_en, o_mem_we, o_mem_addr, o_mem_wdata
   );

   modport master (
      output i_request, i_is_atomic, i_addr, i_dm_write, i_wdata, i_mem_rdata,
      input  o_grant, o_grant_id, o_data_valid, o_data_write_valid, o_rdata,
      input  o_mem_en, o_mem_we, o_mem_addr, o_mem_wdata
   );
endinterface
`default_nettype wire

// File: rtl/ocm_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module  : ocm_arbiter
// Brief   : Round-robin arbiter/controller for a shared 1-cycle-latency OCM.
//           Serves one core at a time (load, store or atomic RMW) and keeps
//           the grant locked across the whole RMW so it is indivisible.
// Revision: 1.0
// ---------------------------------------------------------------------------
module ocm_arbiter #(
   parameter int NUM_CORES = 2,
   parameter int ADDR_BITS = 12,
   parameter int IDX_BITS  = 1
) (
   input  logic          clk,
   input  logic          nrst,
   ocm_arbiter_if.slave  bus
);

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_READ     = 3'd1,
      S_RDATA    = 3'd2,
      S_AMO_WAIT = 3'd3,
      S_WRITE    = 3'd4,
      S_WACK     = 3'd5,
      S_RELEASE  = 3'd6
   } state_t;

   state_t              r_state;
   logic [IDX_BITS-1:0] r_last;
   logic [IDX_BITS-1:0] r_gid;
   logic                r_is_amo;

   logic [ADDR_BITS-1:0] w_addr_arr  [NUM_CORES];
   logic [3:0]           w_we_arr    [NUM_CORES];
   logic [31:0]          w_wdata_arr [NUM_CORES];

   logic                 w_found;
   logic [IDX_BITS-1:0]  w_pick;
   logic [IDX_BITS-1:0]  w_cand;
   logic [NUM_CORES-1:0] w_pick_oh;
   logic [NUM_CORES-1:0] w_gid_oh;
   logic                 w_req_g;

   // Split the flat per-core buses into per-core words
   generate
      for (genvar k = 0; k < NUM_CORES; k++) begin : g_unpack
         assign w_addr_arr[k]  = bus.i_addr[k*ADDR_BITS +: ADDR_BITS];
         assign w_we_arr[k]    = bus.i_dm_write[k*4 +: 4];
         assign w_wdata_arr[k] = bus.i_wdata[k*32 +: 32];
      end
   endgenerate

   assign w_req_g        = bus.i_request[r_gid];
   assign bus.o_grant_id = r_gid;

   // Round-robin search: first requester strictly after the last winner
   always_comb begin
      w_found   = 1'b0;
      w_pick    = '0;
      w_cand    = '0;
      w_pick_oh = '0;
      for (int i = 1; i <= NUM_CORES; i++) begin
         w_cand = IDX_BITS'((int'(r_last) + i) % NUM_CORES);
         if (!w_found && bus.i_request[w_cand]) begin
            w_found = 1'b1;
            w_pick  = w_cand;
         end
      end
      w_pick_oh[w_pick] = 1'b1;
   end

   // One-hot of the currently granted core, used to steer the valid pulses
   always_comb begin
      w_gid_oh        = '0;
      w_gid_oh[r_gid] = 1'b1;
   end

   // RAM port is driven only in the two access states, straight from core g
   always_comb begin
      bus.o_mem_en    = 1'b0;
      bus.o_mem_we    = 4'b0000;
      bus.o_mem_addr  = '0;
      bus.o_mem_wdata = '0;
      if (r_state == S_READ) begin
         bus.o_mem_en   = 1'b1;
         bus.o_mem_addr = w_addr_arr[r_gid];
      end else if (r_state == S_WRITE) begin
         bus.o_mem_en    = 1'b1;
         bus.o_mem_we    = w_we_arr[r_gid];
         bus.o_mem_addr  = w_addr_arr[r_gid];
         bus.o_mem_wdata = w_wdata_arr[r_gid];
      end
   end

   // Transaction sequencer with registered grant, valid pulses and read data
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         r_state                <= S_IDLE;
         r_last                 <= IDX_BITS'(NUM_CORES - 1);
         r_gid                  <= '0;
         r_is_amo               <= 1'b0;
         bus.o_grant            <= '0;
         bus.o_data_valid       <= '0;
         bus.o_data_write_valid <= '0;
         bus.o_rdata            <= '0;
      end else begin
         bus.o_data_valid       <= '0;
         bus.o_data_write_valid <= '0;
         case (r_state)
            S_IDLE: begin
               if (w_found) begin
                  bus.o_grant <= w_pick_oh;
                  r_gid       <= w_pick;
                  r_last      <= w_pick;
                  r_is_amo    <= bus.i_is_atomic[w_pick];
                  if (bus.i_is_atomic[w_pick] || (w_we_arr[w_pick] == 4'b0000))
                     r_state <= S_READ;
                  else
                     r_state <= S_WRITE;
               end
            end
            S_READ: begin
               if (!w_req_g) begin
                  bus.o_grant <= '0;
                  r_gid       <= '0;
                  r_state     <= S_IDLE;
               end else begin
                  r_state <= S_RDATA;
               end
            end
            S_RDATA: begin
               if (!w_req_g) begin
                  bus.o_grant <= '0;
                  r_gid       <= '0;
                  r_state     <= S_IDLE;
               end else begin
                  bus.o_rdata      <= bus.i_mem_rdata;
                  bus.o_data_valid <= w_gid_oh;
                  r_state          <= r_is_amo ? S_AMO_WAIT : S_RELEASE;
               end
            end
            S_AMO_WAIT: begin
               // Grant stays locked here until the core returns the result
               if (!w_req_g) begin
                  bus.o_grant <= '0;
                  r_gid       <= '0;
                  r_state     <= S_IDLE;
               end else if (w_we_arr[r_gid] == 4'b1111) begin
                  r_state <= S_WRITE;
               end
            end
            S_WRITE: begin
               // The RAM write is already on the port this cycle, so a drop
               // here still commits; only the acknowledge is suppressed.
               if (!w_req_g) begin
                  bus.o_grant <= '0;
                  r_gid       <= '0;
                  r_state     <= S_IDLE;
               end else begin
                  r_state <= S_WACK;
               end
            end
            S_WACK: begin
               bus.o_data_write_valid <= w_gid_oh;
               r_state                <= S_RELEASE;
            end
            S_RELEASE: begin
               if (!w_req_g) begin
                  bus.o_grant <= '0;
                  r_gid       <= '0;
                  r_state     <= S_IDLE;
               end
            end
            default: begin
               bus.o_grant <= '0;
               r_gid       <= '0;
               r_state     <= S_IDLE;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_ocm_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module  : tb_ocm_arbiter
// Brief   : Directed self-checking bench for ocm_arbiter with a behavioural
//           byte-writable 1-cycle-latency RAM.
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_ocm_arbiter;

   localparam int c_num_cores = 2;
   localparam int c_addr_bits = 12;
   localparam int c_idx_bits  = 1;
   localparam int c_timeout   = 20;

   logic clk  = 1'b0;
   logic nrst = 1'b0;

   ocm_arbiter_if #(
      .NUM_CORES (c_num_cores),
      .ADDR_BITS (c_addr_bits),
      .IDX_BITS  (c_idx_bits)
   ) bus ();

   ocm_arbiter #(
      .NUM_CORES (c_num_cores),
      .ADDR_BITS (c_addr_bits),
      .IDX_BITS  (c_idx_bits)
   ) dut (
      .clk  (clk),
      .nrst (nrst),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   logic [31:0] ram [0:4095];
   int   n_vec  = 0;
   int   n_err  = 0;
   int   dv_cnt [2] = '{0, 0};
   int   wv_cnt [2] = '{0, 0};
   logic multi  = 1'b0;

   // Behavioural sync RAM: byte writes, read data valid the following cycle
   always @(posedge clk) begin
      if (bus.o_mem_en) begin
         if (bus.o_mem_we == 4'b0000)
            bus.i_mem_rdata <= ram[bus.o_mem_addr];
         else
            for (int b = 0; b < 4; b++)
               if (bus.o_mem_we[b])
                  ram[bus.o_mem_addr][b*8 +: 8] <= bus.o_mem_wdata[b*8 +: 8];
      end
   end

   // Pulse counters and exclusivity watch, sampled mid-cycle
   always @(negedge clk) begin
      if ($countones(bus.o_grant) > 1 ||
          $countones({bus.o_data_valid, bus.o_data_write_valid}) > 1)
         multi <= 1'b1;
      for (int c = 0; c < 2; c++) begin
         if (bus.o_data_valid[c])       dv_cnt[c] <= dv_cnt[c] + 1;
         if (bus.o_data_write_valid[c]) wv_cnt[c] <= wv_cnt[c] + 1;
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic set_core(input logic [0:0] c, input logic req, input logic amo,
                           input logic [11:0] addr, input logic [3:0] we,
                           input logic [31:0] wd);
      bus.i_request[c]           = req;
      bus.i_is_atomic[c]         = amo;
      bus.i_addr[c*12 +: 12]     = addr;
      bus.i_dm_write[c*4 +: 4]   = we;
      bus.i_wdata[c*32 +: 32]    = wd;
   endtask

   // Wait (bounded) for a read or write valid pulse of one core
   task automatic wait_pulse(input logic [0:0] c, input logic wr, output int cyc);
      logic [1:0] v;
      cyc = 0;
      do begin
         @(posedge clk); #1; cyc++;
         v = wr ? bus.o_data_write_valid : bus.o_data_valid;
      end while (!v[c] && cyc < c_timeout);
   endtask

   int         cyc;
   int         left [2];
   logic [0:0] k;
   int         wv_before;

   initial begin
      bus.i_request   = '0;
      bus.i_is_atomic = '0;
      bus.i_addr      = '0;
      bus.i_dm_write  = '0;
      bus.i_wdata     = '0;
      bus.i_mem_rdata = '0;
      ram[12'h010] = 32'hDEADBEEF;
      ram[12'h020] = 32'hAAAAAAAA;
      ram[12'h030] = 32'h30303030;
      ram[12'h031] = 32'h31313131;
      ram[12'h005] = 32'd7;
      ram[12'h006] = 32'h00000055;
      ram[12'h040] = 32'h0BADF00D;
      ram[12'h041] = 32'h11223344;

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      chk("rst_grant", 32'(bus.o_grant), 32'h0);
      chk("rst_gid",   32'(bus.o_grant_id), 32'h0);
      chk("rst_dv",    32'({bus.o_data_valid, bus.o_data_write_valid}), 32'h0);
      chk("rst_rdata", bus.o_rdata, 32'h0);
      chk("rst_memen", 32'(bus.o_mem_en), 32'h0);
      @(negedge clk); nrst = 1'b1;

      // 1: core0 load
      @(negedge clk); set_core(0, 1, 0, 12'h010, 4'h0, 32'h0);
      @(posedge clk); #1;
      chk("t1_grant", 32'(bus.o_grant), 32'h1);
      wait_pulse(0, 0, cyc);
      chk("t1_lat",   32'(cyc), 32'd2);
      chk("t1_rdata", bus.o_rdata, 32'hDEADBEEF);
      @(negedge clk); set_core(0, 0, 0, 12'h0, 4'h0, 32'h0);
      @(posedge clk); #1;
      chk("t1_release", 32'(bus.o_grant), 32'h0);
      chk("t1_dv_once", 32'(dv_cnt[0]), 32'd1);

      // 2: core1 partial store
      @(negedge clk); set_core(1, 1, 0, 12'h020, 4'b0011, 32'h12345678);
      @(posedge clk); #1;
      chk("t2_grant", 32'(bus.o_grant), 32'h2);
      chk("t2_gid",   32'(bus.o_grant_id), 32'h1);
      wait_pulse(1, 1, cyc);
      chk("t2_lat", 32'(cyc), 32'd2);
      @(negedge clk); set_core(1, 0, 0, 12'h0, 4'h0, 32'h0);
      @(posedge clk); #1;
      chk("t2_ram",     ram[12'h020], 32'hAAAA5678);
      chk("t2_wv_once", 32'(wv_cnt[1]), 32'd1);

      // 3: simultaneous loads from reset, two each
      @(negedge clk); nrst = 1'b0;
      @(negedge clk); nrst = 1'b1;
      set_core(0, 1, 0, 12'h030, 4'h0, 32'h0);
      set_core(1, 1, 0, 12'h031, 4'h0, 32'h0);
      left[0] = 2; left[1] = 2;
      for (int t = 0; t < 4; t++) begin
         cyc = 0;
         do begin
            @(posedge clk); #1; cyc++;
         end while (bus.o_data_valid == '0 && cyc < c_timeout);
         chk("t3_seen", 32'(cyc < c_timeout), 32'd1);
         k = bus.o_data_valid[1];
         chk("t3_order", 32'(k), 32'(t % 2));
         chk("t3_rdata", bus.o_rdata, k ? 32'h31313131 : 32'h30303030);
         @(negedge clk); bus.i_request[k] = 1'b0; left[k]--;
         @(negedge clk); if (left[k] > 0) bus.i_request[k] = 1'b1;
      end
      @(posedge clk);

      // 4: core0 AMO with core1 contending during the RMW
      @(negedge clk); set_core(0, 1, 1, 12'h005, 4'h0, 32'h0);
      @(posedge clk); #1;
      chk("t4_grant", 32'(bus.o_grant), 32'h1);
      @(negedge clk); set_core(1, 1, 0, 12'h040, 4'h0, 32'h0);
      wait_pulse(0, 0, cyc);
      chk("t4_lat",   32'(cyc), 32'd2);
      chk("t4_rdata", bus.o_rdata, 32'd7);
      repeat (2) @(posedge clk);
      #1;
      chk("t4_lock", 32'(bus.o_grant), 32'h1);
      @(negedge clk); set_core(0, 1, 1, 12'h005, 4'hF, 32'd10);
      wait_pulse(0, 1, cyc);
      chk("t4_wv_seen",  32'(cyc < c_timeout), 32'd1);
      chk("t4_lock_end", 32'(bus.o_grant), 32'h1);
      chk("t4_ram",      ram[12'h005], 32'd10);
      @(negedge clk); set_core(0, 0, 0, 12'h0, 4'h0, 32'h0);
      @(posedge clk); #1;
      chk("t4_release", 32'(bus.o_grant), 32'h0);
      @(posedge clk); #1;
      chk("t4_grant1", 32'(bus.o_grant), 32'h2);
      wait_pulse(1, 0, cyc);
      chk("t4_rdata1", bus.o_rdata, 32'h0BADF00D);
      @(negedge clk); set_core(1, 0, 0, 12'h0, 4'h0, 32'h0);
      @(posedge clk);

      // 5: core0 AMO aborted in AMO_WAIT
      @(negedge clk); set_core(0, 1, 1, 12'h006, 4'h0, 32'h0);
      @(posedge clk); #1;
      chk("t5_grant", 32'(bus.o_grant), 32'h1);
      @(negedge clk); set_core(1, 1, 0, 12'h041, 4'h0, 32'h0);
      wait_pulse(0, 0, cyc);
      chk("t5_rdata", bus.o_rdata, 32'h00000055);
      wv_before = wv_cnt[0] + wv_cnt[1];
      @(negedge clk); set_core(0, 0, 0, 12'h0, 4'h0, 32'h0);
      @(posedge clk); #1;
      chk("t5_abort", 32'(bus.o_grant), 32'h0);
      @(posedge clk); #1;
      chk("t5_grant1", 32'(bus.o_grant), 32'h2);
      chk("t5_ram",    ram[12'h006], 32'h00000055);
      chk("t5_no_wv",  32'(wv_cnt[0] + wv_cnt[1]), 32'(wv_before));
      wait_pulse(1, 0, cyc);
      chk("t5_rdata1", bus.o_rdata, 32'h11223344);
      @(negedge clk); set_core(1, 0, 0, 12'h0, 4'h0, 32'h0);
      @(posedge clk);

      // 6: async reset in the middle of a read
      @(negedge clk); set_core(0, 1, 0, 12'h010, 4'h0, 32'h0);
      @(posedge clk); #1;
      chk("t6_grant", 32'(bus.o_grant), 32'h1);
      chk("t6_memen", 32'(bus.o_mem_en), 32'h1);
      @(negedge clk); nrst = 1'b0;
      #1;
      chk("t6_rst_grant", 32'(bus.o_grant), 32'h0);
      chk("t6_rst_memen", 32'(bus.o_mem_en), 32'h0);
      chk("t6_rst_rdata", bus.o_rdata, 32'h0);
      set_core(1, 1, 0, 12'h020, 4'h0, 32'h0);
      @(negedge clk); nrst = 1'b1;
      @(posedge clk); #1;
      chk("t6_prio", 32'(bus.o_grant), 32'h1);
      @(negedge clk);
      set_core(0, 0, 0, 12'h0, 4'h0, 32'h0);
      set_core(1, 0, 0, 12'h0, 4'h0, 32'h0);
      repeat (3) @(posedge clk);

      chk("exclusive", 32'(multi), 32'h0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire
